// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer that owns the CSR file port and returns a redirect PC.
// Optional vectored interrupt redirect is enabled by defining TRAP_CTRL_VECTORED_EN.
module trap_ctrl #(
   parameter logic [31:0] IRQ_CAUSE = 32'h8000_000B
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_req,
   input  logic [31:0] exc_cause,
   input  logic [31:0] exc_pc,
   input  logic        mret_req,
   input  logic        irq_ext,
   input  logic        core_csr_we,
   input  logic [11:0] core_csr_addr,
   input  logic [31:0] core_csr_din,
   output logic [31:0] core_csr_dout,
   output logic        csr_we,
   output logic [11:0] csr_addr,
   output logic [31:0] csr_din,
   input  logic [31:0] csr_dout,
   output logic        busy,
   output logic        trap_done,
   output logic [31:0] redirect_pc
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 12;

   localparam logic [3:0] IDLE      = 4'd0;
   localparam logic [3:0] RD_STATUS = 4'd1;
   localparam logic [3:0] RD_MIE    = 4'd2;
   localparam logic [3:0] WR_EPC    = 4'd3;
   localparam logic [3:0] WR_CAUSE  = 4'd4;
   localparam logic [3:0] WR_STATUS = 4'd5;
   localparam logic [3:0] RD_TVEC   = 4'd6;
   localparam logic [3:0] RD_EPC    = 4'd7;
   localparam logic [3:0] DONE      = 4'd8;
   localparam logic [3:0] RESET_STATE = IDLE;

   localparam logic [AW-1:0] A_MSTATUS = 12'h300;
   localparam logic [AW-1:0] A_MIE     = 12'h304;
   localparam logic [AW-1:0] A_MTVEC   = 12'h305;
   localparam logic [AW-1:0] A_MEPC    = 12'h341;
   localparam logic [AW-1:0] A_MCAUSE  = 12'h342;

   localparam logic [1:0] K_EXC  = 2'd0;
   localparam logic [1:0] K_IRQ  = 2'd1;
   localparam logic [1:0] K_MRET = 2'd2;

   localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

   logic [3:0]      state, state_nxt;
   logic [1:0]      kind;
   logic [XLEN-1:0] cause_q, epc_q, status_q;
   logic [XLEN-1:0] trap_status, mret_status, tvec_target;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RESET_STATE;
      else     state <= state_nxt;
   end

   assign busy      = (state != IDLE);
   assign trap_done = (state == DONE);

   // MSTATUS rewrite on trap entry and on MRET
   always_comb begin
      trap_status        = status_q;
      trap_status[7]     = status_q[3];
      trap_status[3]     = 1'b0;
      trap_status[12:11] = 2'b11;
      mret_status        = status_q;
      mret_status[3]     = status_q[7];
      mret_status[7]     = 1'b1;
      mret_status[12:11] = 2'b11;
   end

   always_comb begin
      tvec_target = csr_dout & ALIGN_MASK;
`ifdef TRAP_CTRL_VECTORED_EN
      if (kind == K_IRQ && csr_dout[1:0] == 2'b01)
         tvec_target = (csr_dout & ALIGN_MASK) + {cause_q[29:0], 2'b00};
`endif
   end

   // next state and CSR port mux
   always_comb begin
      state_nxt     = state;
      csr_we        = 1'b0;
      csr_addr      = '0;
      csr_din       = '0;
      core_csr_dout = '0;
      case (state)
         IDLE: begin
            csr_we        = core_csr_we;
            csr_addr      = core_csr_addr;
            csr_din       = core_csr_din;
            core_csr_dout = csr_dout;
            if (exc_req || mret_req || irq_ext) state_nxt = RD_STATUS;
         end
         RD_STATUS: begin
            csr_addr = A_MSTATUS;
            if (kind == K_MRET)     state_nxt = WR_STATUS;
            else if (kind == K_IRQ) state_nxt = csr_dout[3] ? RD_MIE : IDLE;
            else                    state_nxt = WR_EPC;
         end
         RD_MIE: begin
            csr_addr  = A_MIE;
            state_nxt = csr_dout[11] ? WR_EPC : IDLE;
         end
         WR_EPC: begin
            csr_we    = 1'b1;
            csr_addr  = A_MEPC;
            csr_din   = epc_q & ALIGN_MASK;
            state_nxt = WR_CAUSE;
         end
         WR_CAUSE: begin
            csr_we    = 1'b1;
            csr_addr  = A_MCAUSE;
            csr_din   = cause_q;
            state_nxt = WR_STATUS;
         end
         WR_STATUS: begin
            csr_we    = 1'b1;
            csr_addr  = A_MSTATUS;
            csr_din   = (kind == K_MRET) ? mret_status : trap_status;
            state_nxt = (kind == K_MRET) ? RD_EPC : RD_TVEC;
         end
         RD_TVEC: begin
            csr_addr  = A_MTVEC;
            state_nxt = DONE;
         end
         RD_EPC: begin
            csr_addr  = A_MEPC;
            state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // capture registers and redirect target
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kind        <= K_EXC;
         cause_q     <= '0;
         epc_q       <= '0;
         status_q    <= '0;
         redirect_pc <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (exc_req) begin
                  kind    <= K_EXC;
                  cause_q <= exc_cause;
                  epc_q   <= exc_pc;
               end else if (mret_req) begin
                  kind <= K_MRET;
               end else if (irq_ext) begin
                  kind    <= K_IRQ;
                  cause_q <= IRQ_CAUSE;
                  epc_q   <= exc_pc;
               end
            end
            RD_STATUS: status_q    <= csr_dout;
            RD_TVEC:   redirect_pc <= tvec_target;
            RD_EPC:    redirect_pc <= csr_dout & ALIGN_MASK;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed scenarios plus randomized traffic checked every cycle against a
// transaction-level model of the trap sequencer and its CSR file.
module tb_trap_ctrl;
   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;

   logic        clk, rst;
   logic        exc_req, mret_req, irq_ext;
   logic [31:0] exc_cause, exc_pc;
   logic        core_csr_we;
   logic [11:0] core_csr_addr;
   logic [31:0] core_csr_din, core_csr_dout;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_din, csr_dout;
   logic        busy, trap_done;
   logic [31:0] redirect_pc;

   int checks = 0;
   int failures = 0;

   trap_ctrl dut (
      .clk(clk), .rst(rst),
      .exc_req(exc_req), .exc_cause(exc_cause), .exc_pc(exc_pc),
      .mret_req(mret_req), .irq_ext(irq_ext),
      .core_csr_we(core_csr_we), .core_csr_addr(core_csr_addr),
      .core_csr_din(core_csr_din), .core_csr_dout(core_csr_dout),
      .csr_we(csr_we), .csr_addr(csr_addr), .csr_din(csr_din), .csr_dout(csr_dout),
      .busy(busy), .trap_done(trap_done), .redirect_pc(redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // CSR file the DUT drives
   logic [31:0] mem [4096];
   assign csr_dout = mem[csr_addr];
   always @(posedge clk) if (csr_we) mem[csr_addr] <= csr_din;

   // model: expected CSR contents and the per-cycle plan of an accepted request
   typedef struct packed {
      logic        we;
      logic        rd;
      logic        done;
      logic [11:0] addr;
      logic [31:0] din;
      logic [31:0] redir;
   } step_t;

   logic [31:0] ref_csr [4096];
   step_t       plan [$];
   step_t       cur;
   logic [31:0] exp_redir = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic step_t mk(input logic we, input logic rd, input logic done,
                                input logic [11:0] a, input logic [31:0] d, input logic [31:0] r);
      step_t s;
      s.we = we; s.rd = rd; s.done = done; s.addr = a; s.din = d; s.redir = r;
      return s;
   endfunction

   task automatic build_plan();
      logic [31:0] st, cause, pc, tv, redir, ns;
      logic is_irq;
      st = ref_csr[A_MSTATUS];
      is_irq = 1'b0;
      cause = '0;
      pc = '0;
      plan.push_back(mk(1'b0, 1'b1, 1'b0, A_MSTATUS, '0, '0));
      if (mret_req && !exc_req) begin
         ns = (st & ~32'h1888) | (st[7] ? 32'h8 : 32'h0) | 32'h80 | 32'h1800;
         plan.push_back(mk(1'b1, 1'b0, 1'b0, A_MSTATUS, ns, '0));
         plan.push_back(mk(1'b0, 1'b1, 1'b0, A_MEPC, '0, '0));
         plan.push_back(mk(1'b0, 1'b0, 1'b1, 12'h0, '0, ref_csr[A_MEPC] & ~32'h3));
         return;
      end
      if (exc_req) begin
         cause = exc_cause;
         pc = exc_pc;
      end else begin
         is_irq = 1'b1;
         cause = 32'h8000_000B;
         pc = exc_pc;
         if (!st[3]) return;
         plan.push_back(mk(1'b0, 1'b1, 1'b0, A_MIE, '0, '0));
         if (!ref_csr[A_MIE][11]) return;
      end
      ns = (st & ~32'h1888) | (st[3] ? 32'h80 : 32'h0) | 32'h1800;
      plan.push_back(mk(1'b1, 1'b0, 1'b0, A_MEPC, pc & ~32'h3, '0));
      plan.push_back(mk(1'b1, 1'b0, 1'b0, A_MCAUSE, cause, '0));
      plan.push_back(mk(1'b1, 1'b0, 1'b0, A_MSTATUS, ns, '0));
      plan.push_back(mk(1'b0, 1'b1, 1'b0, A_MTVEC, '0, '0));
      tv = ref_csr[A_MTVEC];
      redir = tv & ~32'h3;
`ifdef TRAP_CTRL_VECTORED_EN
      if (is_irq && tv[1:0] == 2'b01) redir = redir + (32'(cause[30:0]) << 2);
`else
      if (is_irq) redir = tv & ~32'h3;
`endif
      plan.push_back(mk(1'b0, 1'b0, 1'b1, 12'h0, '0, redir));
   endtask

   // per-cycle compare against the model
   always @(negedge clk) begin
      if (rst) begin
         plan.delete();
         exp_redir = '0;
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_trap_done", 32'(trap_done), 32'd0);
         chk("rst_redirect", redirect_pc, 32'd0);
      end else if (plan.size() == 0) begin
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_trap_done", 32'(trap_done), 32'd0);
         chk("idle_we", 32'(csr_we), 32'(core_csr_we));
         chk("idle_addr", 32'(csr_addr), 32'(core_csr_addr));
         chk("idle_din", csr_din, core_csr_din);
         chk("idle_dout", core_csr_dout, ref_csr[core_csr_addr]);
         chk("idle_redirect", redirect_pc, exp_redir);
         if (core_csr_we) ref_csr[core_csr_addr] = core_csr_din;
         if (exc_req || mret_req || irq_ext) build_plan();
      end else begin
         cur = plan.pop_front();
         chk("seq_busy", 32'(busy), 32'd1);
         chk("seq_core_dout", core_csr_dout, 32'd0);
         chk("seq_we", 32'(csr_we), 32'(cur.we));
         if (cur.we || cur.rd) chk("seq_addr", 32'(csr_addr), 32'(cur.addr));
         if (cur.we) chk("seq_din", csr_din, cur.din);
         chk("seq_trap_done", 32'(trap_done), 32'(cur.done));
         if (cur.done) exp_redir = cur.redir;
         chk("seq_redirect", redirect_pc, exp_redir);
         if (cur.we) ref_csr[cur.addr] = cur.din;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic core_write(input logic [11:0] a, input logic [31:0] d);
      core_csr_we = 1'b1;
      core_csr_addr = a;
      core_csr_din = d;
      cyc();
      core_csr_we = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!trap_done && n < 20);
      if (!trap_done) begin
         checks++;
         failures++;
         $display("FAIL wait_done timeout after %0d cycles", n);
      end
   endtask

   function automatic logic [11:0] pick_addr(input int unsigned k);
      case (k)
         0: return A_MSTATUS;
         1: return A_MIE;
         2: return A_MTVEC;
         3: return A_MSCRATCH;
         4: return A_MEPC;
         default: return A_MCAUSE;
      endcase
   endfunction

   int n;
   int unsigned r;

   initial begin
      rst = 1'b1;
      {exc_req, mret_req, irq_ext, core_csr_we} = '0;
      exc_cause = '0; exc_pc = '0; core_csr_addr = '0; core_csr_din = '0;
      for (int i = 0; i < 4096; i++) begin
         mem[i] = '0;
         ref_csr[i] = '0;
      end
      repeat (2) cyc();
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_trap_done", 32'(trap_done), 32'd0);
      chk("reset_redirect", redirect_pc, 32'd0);
      chk("reset_csr_we", 32'(csr_we), 32'd0);
      rst = 1'b0;
      cyc();

      // idle pass-through
      core_write(A_MSCRATCH, 32'hDEAD_BEEF);
      core_csr_addr = A_MSCRATCH;
      #1;
      chk("t1_read", core_csr_dout, 32'hDEAD_BEEF);
      chk("t1_busy", 32'(busy), 32'd0);

      // exception
      core_write(A_MSTATUS, 32'h8);
      core_write(A_MTVEC, 32'h100);
      exc_req = 1'b1; exc_cause = 32'd2; exc_pc = 32'h2004;
      wait_done(n);
      chk("t2_latency", 32'(n), 32'd6);
      chk("t2_redirect", redirect_pc, 32'h100);
      exc_req = 1'b0;
      cyc();
      chk("t2_mepc", mem[A_MEPC], 32'h2004);
      chk("t2_mcause", mem[A_MCAUSE], 32'd2);
      chk("t2_mstatus", mem[A_MSTATUS], 32'h1880);
      chk("t2_model_mstatus", ref_csr[A_MSTATUS], 32'h1880);

      // MRET
      mret_req = 1'b1;
      wait_done(n);
      chk("t3_latency", 32'(n), 32'd4);
      chk("t3_redirect", redirect_pc, 32'h2004);
      mret_req = 1'b0;
      cyc();
      chk("t3_mstatus", mem[A_MSTATUS], 32'h1888);
      chk("t3_model_mstatus", ref_csr[A_MSTATUS], 32'h1888);

      // masked interrupt, then enabled interrupt
      core_write(A_MSTATUS, 32'h0);
      irq_ext = 1'b1; exc_pc = 32'h3000;
      cyc();
      irq_ext = 1'b0;
      chk("t4_abort_busy", 32'(busy), 32'd1);
      cyc();
      chk("t4_abort_idle", 32'(busy), 32'd0);
      chk("t4_abort_mcause", mem[A_MCAUSE], 32'd2);
      core_write(A_MSTATUS, 32'h8);
      core_write(A_MIE, 32'h800);
      irq_ext = 1'b1;
      wait_done(n);
      chk("t4_latency", 32'(n), 32'd7);
      chk("t4_redirect", redirect_pc, 32'h100);
      irq_ext = 1'b0;
      cyc();
      chk("t4_mcause", mem[A_MCAUSE], 32'h8000_000B);
      chk("t4_mepc", mem[A_MEPC], 32'h3000);

      // simultaneous requests; core writes ignored while busy
      exc_req = 1'b1; mret_req = 1'b1; irq_ext = 1'b1;
      exc_cause = 32'd5; exc_pc = 32'h4000;
      cyc();
      core_csr_we = 1'b1; core_csr_addr = A_MSCRATCH; core_csr_din = 32'h1234_5678;
      wait_done(n);
      chk("t5_latency", 32'(n + 1), 32'd6);
      {exc_req, mret_req, irq_ext, core_csr_we} = '0;
      cyc();
      chk("t5_mscratch", mem[A_MSCRATCH], 32'hDEAD_BEEF);
      chk("t5_mcause", mem[A_MCAUSE], 32'd5);
      chk("t5_mepc", mem[A_MEPC], 32'h4000);

      // reset in WR_CAUSE
      exc_req = 1'b1; exc_cause = 32'd7; exc_pc = 32'h5008;
      repeat (3) cyc();
      rst = 1'b1;
      #1;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_trap_done", 32'(trap_done), 32'd0);
      exc_req = 1'b0;
      cyc();
      rst = 1'b0;
      cyc();
      chk("t6_mepc", mem[A_MEPC], 32'h5008);
      chk("t6_mcause", mem[A_MCAUSE], 32'd5);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (busy) begin
            if (trap_done || $urandom_range(0, 15) == 0) {exc_req, mret_req, irq_ext} = '0;
         end else begin
            r = $urandom_range(0, 9);
            exc_req  = (r == 0) || (r == 5);
            mret_req = (r == 1) || (r == 5);
            irq_ext  = (r == 2) || (r == 3) || (r == 5);
         end
         exc_cause = $urandom;
         exc_pc = $urandom;
         core_csr_we = ($urandom_range(0, 2) == 0);
         core_csr_addr = pick_addr($urandom_range(0, 5));
         core_csr_din = $urandom;
         cyc();
      end
      {exc_req, mret_req, irq_ext, core_csr_we} = '0;
      repeat (10) cyc();
      for (int k = 0; k < 6; k++) chk("final_csr", mem[pick_addr(k)], ref_csr[pick_addr(k)]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
